// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the CPU data-memory port and its responder.
// Latency: none (wires only).
// Backpressure: none; the requester holds its request until memReady, which ends the transaction.
// Signals: memRead/memWrite request levels, address word address, writeData store data,
//          readData registered load data, memReady one-cycle completion, memError error
//          qualifier for memReady, busy transaction in progress.
// With DATA_MEM_ACCESS_COUNT_EN defined, readCount/writeCount carry the successful access counters.
interface data_mem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        memReady;
  logic        memError;
  logic        busy;
`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [31:0] readCount;
  logic [31:0] writeCount;

  modport master (
    output memRead, memWrite, address, writeData,
    input  readData, memReady, memError, busy, readCount, writeCount
  );
  modport slave (
    input  memRead, memWrite, address, writeData,
    output readData, memReady, memError, busy, readCount, writeCount
  );
`else
  modport master (
    output memRead, memWrite, address, writeData,
    input  readData, memReady, memError, busy
  );
  modport slave (
    input  memRead, memWrite, address, writeData,
    output readData, memReady, memError, busy
  );
`endif
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, completes it with a one-cycle memReady.
// Latency: memReady is high WAIT_CYCLES+1 cycles after the accepting edge; throughput one per WAIT_CYCLES+2.
// Backpressure: none; requests are only sampled in IDLE, so a held request is simply re-accepted there.
// Ports: sysClk clock, reset async active-high, bus (data_mem_responder_if.slave) request/response.
// Optional: define DATA_MEM_ACCESS_COUNT_EN to add readCount/writeCount successful-access counters.
module data_mem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 sysClk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // With no wait states the accepting edge is also the completion edge, so the live
  // inputs are used directly instead of the latched copies.
  localparam bit BYPASS = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, nextState;
  logic [3:0]  waitCnt, nextWaitCnt;
  logic [31:0] addrQ, dataQ;
  logic        readQ, writeQ;
  logic [31:0] readDataQ;
  logic        errQ;

  logic        req, accept, complete;
  logic [31:0] compAddr, compData;
  logic        compRead, compWrite, compErr;
  logic [AW-1:0] compIdx;
  logic        doWrite, doRead;

  logic [31:0] mem [DEPTH];

  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    complete    = 1'b0;
    req         = bus.memRead | bus.memWrite;
    accept      = (state == IDLE) && req;
    case (state)
      IDLE: begin
        if (req) begin
          if (BYPASS) begin
            nextState = RESP;
            complete  = 1'b1;
          end else begin
            nextState   = WAIT;
            nextWaitCnt = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          nextState = RESP;
          complete  = 1'b1;
        end else begin
          nextWaitCnt = waitCnt - 4'd1;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    compAddr  = BYPASS ? bus.address   : addrQ;
    compData  = BYPASS ? bus.writeData : dataQ;
    compRead  = BYPASS ? bus.memRead   : readQ;
    compWrite = BYPASS ? bus.memWrite  : writeQ;
    // Full 32-bit compare: high address bits must not alias onto valid words.
    compErr   = (compRead & compWrite) | (compAddr >= 32'(DEPTH));
    compIdx   = compAddr[AW-1:0];
    doWrite   = complete & compWrite & ~compErr;
    doRead    = complete & compRead & ~compErr;
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      addrQ     <= 32'd0;
      dataQ     <= 32'd0;
      readQ     <= 1'b0;
      writeQ    <= 1'b0;
      readDataQ <= 32'd0;
      errQ      <= 1'b0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
      if (accept) begin
        addrQ  <= bus.address;
        dataQ  <= bus.writeData;
        readQ  <= bus.memRead;
        writeQ <= bus.memWrite;
      end
      if (complete) begin
        errQ <= compErr;
        // Writes leave readData alone so a late sampler still sees the last load.
        if (compErr)
          readDataQ <= 32'd0;
        else if (doRead)
          readDataQ <= mem[compIdx];
      end
    end
  end

  // Storage has no reset: contents survive a reset.
  always_ff @(posedge sysClk) begin
    if (doWrite)
      mem[compIdx] <= compData;
  end

`ifdef DATA_MEM_ACCESS_COUNT_EN
  logic [31:0] readCountQ, writeCountQ;

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      readCountQ  <= 32'd0;
      writeCountQ <= 32'd0;
    end else begin
      if (doRead)
        readCountQ <= readCountQ + 32'd1;
      if (doWrite)
        writeCountQ <= writeCountQ + 32'd1;
    end
  end

  assign bus.readCount  = readCountQ;
  assign bus.writeCount = writeCountQ;
`endif

  assign bus.readData = readDataQ;
  assign bus.memReady = (state == RESP);
  assign bus.memError = errQ & (state == RESP);
  assign bus.busy     = (state != IDLE);
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's data-memory load/store requests.
- Accepts a single read or write request, holds it for a programmable number of wait states, then completes it with a one-cycle ready pulse.
- Sits between the controller/ALU result register on the CPU side and a word-addressed storage array.
- Replaces the zero-latency data RAM so that slow memory can be modelled and its errors reported.

Parameters:
- DEPTH, 1024: number of 32-bit words; valid word addresses are 0..DEPTH-1.
- WAIT_CYCLES, 2: wait states between request acceptance and completion; range 0..15.

Ports:
- sysClk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- memRead  input  1  read request level.
- memWrite  input  1  write request level.
- address  input  32  word address.
- writeData  input  32  store data.
- readData  output  32  load data, registered.
- memReady  output  1  completion pulse, one cycle wide.
- memError  output  1  error flag; valid only while memReady=1.
- busy  output  1  high while a request is in progress (WAIT or RESP).

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - readData=0, memReady=0, memError=0, busy=0.
  - Wait counter=0 and any pending request is discarded.
  - The storage array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request is present when memRead|memWrite=1.
  - On the accepting edge E0, latch address, writeData, memRead and memWrite.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or RESP if WAIT_CYCLES=0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, the next state is RESP.
  - Input changes are ignored; only the latched copies are used.
- Completion edge (the edge entering RESP, edge E0+WAIT_CYCLES):
  - Valid write: write the latched data to the latched address. readData is unchanged.
  - Valid read: readData <= mem[latched address].
  - Error: no write, readData <= 0, and the error is registered.
- RESP:
  - memReady=1 and memError is valid, both for exactly one cycle.
  - busy stays 1.
  - Next state is IDLE unconditionally.
- Latency: memReady is high in the cycle after edge E0+WAIT_CYCLES. With the default of 2, memReady rises 3 cycles after acceptance.
- readData holds its value until the next read or error completion, so the data memory register can sample it late.
- Requester rule: the requester drops its request on the edge that ends RESP. A request still high in IDLE is accepted again as a new transaction. Back-to-back throughput is one transaction per WAIT_CYCLES+2 cycles.
- Error conditions (completion still happens with memReady=1, memError=1):
  - address >= DEPTH, compared on the full 32 bits with no wrap-around.
  - memRead and memWrite both 1 at acceptance; neither a read nor a write is performed.
- Reset mid-WAIT or mid-RESP: abort immediately; no write, no memReady pulse.
- Storage is inferred single-port; only one access per transaction.

Optional Feature:
- Macro: DATA_MEM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs readCount[31:0] and writeCount[31:0], both reset to 0.
  - Each increments by 1 on the completion edge of a successful read or write respectively.
  - Erroring transactions are not counted.
  - Counters wrap from 0xFFFFFFFF to 0.
- When undefined: these ports and their counter logic do not exist; all other behaviour is identical.

Test Plan:
- Write then read back:
  - With WAIT_CYCLES=2: write 0xDEADBEEF to address 5, then read address 5.
  - Each memReady pulses 3 cycles after acceptance.
  - readData=0xDEADBEEF; memError=0 on both.
- Input stability:
  - Change address to 7 during WAIT of a read of address 5.
  - readData returns mem[5].
- Out of range:
  - Write 0x12345678 to address 1024 (DEPTH=1024).
  - memReady=1, memError=1; a subsequent read of address 0 returns its prior value.
  - Reading address 1024 gives readData=0 with memError=1.
- Both requests asserted:
  - memRead=memWrite=1 at address 3.
  - memError=1; mem[3] is unchanged.
- Zero wait states and back-to-back:
  - WAIT_CYCLES=0: memReady is high the cycle after acceptance.
  - A request held high is re-accepted every 2 cycles.
- Reset mid-operation:
  - Assert reset during WAIT of a write of 0xA5A5A5A5 to address 9.
  - Outputs go to 0 immediately with no memReady pulse; mem[9] keeps its old value.
  - With DATA_MEM_ACCESS_COUNT_EN defined, counters read 0 after reset.
